// File: rtl/dffs_drain_pkg.sv
// dffs_drain_pkg: shared state encoding for the DFF array drain block.
//   Defines drain_state_t.
//   It is used by dffs_drain and dffs_prio_enc.
package dffs_drain_pkg;
   typedef enum logic [1:0] {
      DRAIN_IDLE = 2'd0,
      DRAIN_SCAN = 2'd1,
      DRAIN_SEND = 2'd2,
      DRAIN_FIN  = 2'd3
   } drain_state_t;
endpackage

// File: rtl/dffs_prio_enc.sv
// dffs_prio_enc: finds the lowest set bit of a vector at or above a start pointer.
//   vector : 2**SIZE request bits
//   PTR    : SIZE+1 bit start index; a value of 2**SIZE or more always gives "none found"
//   FOUND  : at least one qualifying bit is set
//   IDX    : index of the lowest qualifying bit (0 when FOUND=0)
module dffs_prio_enc
   import dffs_drain_pkg::*;
#(
   parameter int SIZE = 3
) (
   input  logic [2**SIZE-1:0] vector,
   input  logic [SIZE:0]      PTR,
   output logic               FOUND,
   output logic [SIZE-1:0]    IDX
);
   localparam int N = 2**SIZE;
   localparam int W = SIZE + 1;
   // The loop runs from the top index down, so the last hit is the lowest index.
   always_comb begin
      FOUND = 1'b0;
      IDX   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vector[i] && (W'(i) >= PTR)) begin
            FOUND = 1'b1;
            IDX   = SIZE'(i);
         end
      end
   end
endmodule

// File: rtl/dffs_drain.sv
// dffs_drain: streams the dirty words of a packed DFF array out over valid/ready.
//   CLK, RST      : clock; synchronous active-high reset
//   START         : one-cycle pulse that begins a pass (ignored while BUSY)
//   BUSY, DONE    : pass in progress / one-cycle pass-complete pulse
//   DFF, DIRTY    : packed array contents (word i at [i*WLEN+:WLEN]) and per-word dirty flags
//   CLRN          : active-low one-cycle clear strobe per accepted word (array WENB, MASK tied high)
//   OVALID/OREADY : output handshake; OADDR/ODATA give the index and the snapshot of the word
//   Define DFFS_DRAIN_CLEAR_EN to enable the CLRN strobes (flush).
//   Without it, CLRN stays all ones (non-destructive dump).
module dffs_drain
   import dffs_drain_pkg::*;
#(
   parameter int SIZE = 3,
   parameter int WLEN = 32
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      START,
   output logic                      BUSY,
   output logic                      DONE,
   input  logic [WLEN*(2**SIZE)-1:0] DFF,
   input  logic [2**SIZE-1:0]        DIRTY,
   output logic [2**SIZE-1:0]        CLRN,
   output logic                      OVALID,
   input  logic                      OREADY,
   output logic [SIZE-1:0]           OADDR,
   output logic [WLEN-1:0]           ODATA
);
   localparam int N = 2**SIZE;
   localparam logic [SIZE-1:0] LAST = SIZE'(N - 1);
   drain_state_t state, state_n;
   logic [SIZE:0] ptr;
   logic found;
   logic [SIZE-1:0] idx;
   logic [WLEN-1:0] words [N];
   logic hs;
   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_unpk
         assign words[g] = DFF[g*WLEN +: WLEN];
      end
   endgenerate
   dffs_prio_enc #(.SIZE(SIZE)) u_enc (
      .vector (DIRTY),
      .PTR    (ptr),
      .FOUND  (found),
      .IDX    (idx)
   );
   assign hs   = (state == DRAIN_SEND) && OREADY;
   assign BUSY = (state == DRAIN_SCAN) || (state == DRAIN_SEND);
   assign DONE = (state == DRAIN_FIN);
   always_comb begin
      state_n = state;
      case (state)
         DRAIN_IDLE: state_n = START ? DRAIN_SCAN : DRAIN_IDLE;
         DRAIN_SCAN: state_n = found ? DRAIN_SEND : DRAIN_FIN;
         DRAIN_SEND: state_n = !OREADY ? DRAIN_SEND : (OADDR == LAST) ? DRAIN_FIN : DRAIN_SCAN;
         default:    state_n = DRAIN_IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= DRAIN_IDLE;
         ptr    <= '0;
         OVALID <= 1'b0;
         OADDR  <= '0;
         ODATA  <= '0;
      end else begin
         state <= state_n;
         if ((state == DRAIN_IDLE) && START)
            ptr <= '0;
         if ((state == DRAIN_SCAN) && found) begin
            OVALID <= 1'b1;
            OADDR  <= idx;
            ODATA  <= words[idx];
         end
         // After the last index the pointer reaches N, which the encoder treats as "none found".
         if (hs) begin
            OVALID <= 1'b0;
            ptr    <= {1'b0, OADDR} + (SIZE+1)'(1);
         end
      end
   end
`ifdef DFFS_DRAIN_CLEAR_EN
   // Every bit returns high each cycle, so a strobe lasts exactly one cycle after the accept.
   always_ff @(posedge CLK) begin
      if (RST) begin
         CLRN <= '1;
      end else begin
         CLRN <= '1;
         if (hs)
            CLRN[OADDR] <= 1'b0;
      end
   end
`else
   assign CLRN = '1;
`endif
endmodule

// File: tb/tb_dffs_drain.sv
// tb_dffs_drain: scoreboard bench for dffs_drain with directed passes.
module tb_dffs_drain;
   localparam int SIZE = 3;
   localparam int WLEN = 32;
   localparam int N    = 8;
   logic CLK = 1'b0;
   logic RST, START, OREADY, BUSY, DONE, OVALID;
   logic [WLEN*N-1:0] DFF;
   logic [N-1:0] DIRTY, CLRN;
   logic [SIZE-1:0] OADDR;
   logic [WLEN-1:0] ODATA;
   int tests = 0;
   int fails = 0;
   logic [SIZE+WLEN-1:0] sb [$];
   logic hs_prev = 1'b0, stall_prev = 1'b0;
   logic [SIZE-1:0] addr_prev = '0;
   logic [WLEN-1:0] data_prev = '0;
   always #5 CLK = ~CLK;
   dffs_drain #(.SIZE(SIZE), .WLEN(WLEN)) dut (
      .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
      .DFF(DFF), .DIRTY(DIRTY), .CLRN(CLRN), .OVALID(OVALID), .OREADY(OREADY),
      .OADDR(OADDR), .ODATA(ODATA)
   );
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask
   // Monitor: samples 1ns after the falling edge, when the bench's inputs for the next rising edge are settled.
   always begin
      logic [N-1:0] exp_clrn;
      logic [SIZE+WLEN-1:0] e;
      @(negedge CLK);
      #1;
      exp_clrn = '1;
`ifdef DFFS_DRAIN_CLEAR_EN
      if (hs_prev) exp_clrn[addr_prev] = 1'b0;
`endif
      chk("clrn", 64'(CLRN), 64'(exp_clrn));
      if (stall_prev && OVALID && !RST) begin
         chk("stable_addr", 64'(OADDR), 64'(addr_prev));
         chk("stable_data", 64'(ODATA), 64'(data_prev));
      end
      if (OVALID && OREADY && !RST) begin
         if (sb.size() == 0) begin
            chk("unexpected_word", 64'(OADDR), 64'hFFFF);
         end else begin
            e = sb.pop_front();
            chk("oaddr", 64'(OADDR), 64'(e[SIZE+WLEN-1:WLEN]));
            chk("odata", 64'(ODATA), 64'(e[WLEN-1:0]));
         end
      end
      hs_prev    = OVALID && OREADY && !RST;
      stall_prev = OVALID && !OREADY && !RST;
      addr_prev  = OADDR;
      data_prev  = ODATA;
   end
   task automatic pulse_start();
      @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask
   task automatic wait_done(input string name);
      int n = 0;
      while (!DONE && n < 200) begin
         @(negedge CLK);
         n++;
      end
      chk(name, 64'(DONE), 64'd1);
      @(negedge CLK);
      chk("done_pulse", 64'(DONE), 64'd0);
      chk("sb_empty", 64'(sb.size()), 64'd0);
   endtask
   task automatic wait_valid();
      int n = 0;
      while (!OVALID && n < 50) begin
         @(negedge CLK);
         n++;
      end
      chk("valid_seen", 64'(OVALID), 64'd1);
   endtask
   initial begin
      RST = 1'b1; START = 1'b0; OREADY = 1'b1; DIRTY = '0;
      for (int i = 0; i < N; i++) DFF[i*WLEN +: WLEN] = i * 32'h11111111;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      chk("rst_busy", 64'(BUSY), 64'd0);
      chk("rst_done", 64'(DONE), 64'd0);
      chk("rst_ovalid", 64'(OVALID), 64'd0);
      chk("rst_oaddr", 64'(OADDR), 64'd0);
      chk("rst_odata", 64'(ODATA), 64'd0);
      // Empty array: BUSY only in t+1, DONE at t+2.
      pulse_start();
      chk("empty_busy_t1", 64'(BUSY), 64'd1);
      chk("empty_done_t1", 64'(DONE), 64'd0);
      @(negedge CLK);
      chk("empty_busy_t2", 64'(BUSY), 64'd0);
      chk("empty_done_t2", 64'(DONE), 64'd1);
      chk("empty_ovalid", 64'(OVALID), 64'd0);
      @(negedge CLK);
      chk("empty_done_t3", 64'(DONE), 64'd0);
      // Dirty words 0, 2, 7 with OREADY high.
      DIRTY = 8'b1000_0101;
      sb.push_back({3'd0, 32'h00000000});
      sb.push_back({3'd2, 32'h22222222});
      sb.push_back({3'd7, 32'h77777777});
      pulse_start();
      chk("first_ovalid_t1", 64'(OVALID), 64'd0);
      @(negedge CLK);
      chk("first_ovalid_t2", 64'(OVALID), 64'd1);
      wait_done("done_stream");
      // Stall on index 2 for 10 cycles; a DFF write after the snapshot must not reach ODATA.
      DIRTY = 8'h04; OREADY = 1'b0;
      sb.push_back({3'd2, 32'h22222222});
      pulse_start();
      wait_valid();
      DFF[2*WLEN +: WLEN] = 32'hDEADBEEF;
      repeat (10) @(negedge CLK);
      chk("stall_ovalid", 64'(OVALID), 64'd1);
      OREADY = 1'b1;
      wait_done("done_stall");
      DFF[2*WLEN +: WLEN] = 32'h22222222;
      // Dirty bits set mid-pass: 1 is behind the pointer, 5 is ahead.
      DIRTY = 8'h04;
      sb.push_back({3'd2, 32'h22222222});
      sb.push_back({3'd5, 32'h55555555});
      pulse_start();
      wait_valid();
      DIRTY = 8'h26;
      wait_done("done_midpass");
      // Reset while index 2 waits in SEND, then drain it again.
      DIRTY = 8'h04; OREADY = 1'b0;
      pulse_start();
      wait_valid();
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("midrst_busy", 64'(BUSY), 64'd0);
      chk("midrst_ovalid", 64'(OVALID), 64'd0);
      chk("midrst_oaddr", 64'(OADDR), 64'd0);
      chk("midrst_odata", 64'(ODATA), 64'd0);
      OREADY = 1'b1;
      sb.push_back({3'd2, 32'h22222222});
      pulse_start();
      wait_done("done_redrain");
      repeat (2) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/dffs_drain.md
Name: dffs_drain

Overview:
- Sequential reader for masked dual-port DFF arrays. It walks the packed DFF contents bus and a per-word dirty vector, and streams each dirty word out through a valid/ready handshake.
- On each accepted word it issues a one-cycle active-low clear strobe back to the array's write-B side (WENB/MASK) for that index.
- Used for cache/tag write-back flush and for register-file state dump.

Parameters:
- SIZE, 3, log2 of word count (array holds 2**SIZE words)
- WLEN, 32, word width in bits

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- START  in  1  one-cycle pulse; begins a drain pass; ignored while BUSY
- BUSY  out  1  high from the cycle after an accepted START until the cycle DONE asserts
- DONE  out  1  one-cycle pulse when the pass completes
- DFF  in  WLEN*(2**SIZE)  packed array contents; word i at [i*WLEN+:WLEN]
- DIRTY  in  2**SIZE  per-word dirty flags, active-high
- CLRN  out  2**SIZE  active-low clear strobe per word; drives array WENB, with MASK tied high
- OVALID  out  1  output word valid
- OREADY  in  1  downstream accept
- OADDR  out  SIZE  index of the output word
- ODATA  out  WLEN  output word, snapshot taken at selection

Behaviour:
- Reset values: BUSY=0, DONE=0, OVALID=0, CLRN=all ones, OADDR=0, ODATA=0; internal pointer PTR=0; state=IDLE.
- FSM states: IDLE, SCAN, SEND, FIN.
- IDLE:
  - START=1 -> SCAN, PTR<=0.
  - Otherwise stay in IDLE.
- SCAN (one cycle per step):
  - Priority-encode the lowest index i >= PTR with DIRTY[i]=1.
  - If found: OADDR<=i, ODATA<=DFF word i, OVALID<=1 -> SEND.
  - If none found -> FIN.
- SEND:
  - OVALID, OADDR and ODATA stay stable until OREADY=1.
  - On the handshake (OVALID&&OREADY): OVALID<=0 and CLRN[OADDR]<=0 for exactly the next cycle.
  - After the handshake: if OADDR==2**SIZE-1 -> FIN, else PTR<=OADDR+1 -> SCAN.
- FIN: DONE=1 for one cycle, BUSY<=0 -> IDLE.
- Latency:
  - START in cycle t -> BUSY=1 at t+1; first OVALID at t+2.
  - Back-to-back words are spaced at least 2 cycles apart (SCAN+SEND).
  - Empty array: DONE at t+2.
- Width rules:
  - PTR is SIZE+1 bits so no wrap occurs. PTR reaching 2**SIZE is treated as "none found".
  - A pass never revisits lower indices.
- Boundary conditions:
  - DIRTY[i] set behind PTR during a pass: not drained in this pass.
  - DIRTY[i] set at or ahead of PTR: drained in this pass.
  - DFF word changes after snapshot: ODATA keeps the old value. The array owner must not write a word that is pending in SEND.
  - OREADY held high in SCAN: no effect.
  - OREADY low indefinitely: block holds in SEND, no timeout.
  - START in the same cycle as DONE: ignored. START must come after BUSY=0 and DONE=0.
  - RST mid-pass: synchronous return to reset values next edge. No CLRN strobe is issued for an in-flight word, and that word stays dirty.

Optional Feature:
- DFFS_DRAIN_CLEAR_EN defined: CLRN strobes as specified (flush semantics).
- Not defined: CLRN is constant all ones and DIRTY is never cleared (non-destructive dump). All other timing is identical.

Decomposition:
- defines.v:
  - FSM state encodings: DRAIN_IDLE=2'd0, DRAIN_SCAN=2'd1, DRAIN_SEND=2'd2, DRAIN_FIN=2'd3.
  - Reuse the existing MIN and UNPK_ARRAY macros to unpack DFF.
- One sub-module, dffs_prio_enc:
  - Parameter SIZE.
  - Inputs: vector, PTR.
  - Outputs: FOUND, IDX (lowest set bit at or above PTR).
  - Purely combinational, instantiated once.

Test Plan:
- SIZE=3, DIRTY=8'h00, START -> no OVALID; DONE pulse at t+2; BUSY high only in t+1.
- DIRTY=8'b1000_0101, words = index*0x11111111, OREADY=1 -> outputs (0,0x00000000), (2,0x22222222), (7,0x77777777) in order. CLRN pulses 8'hFE, 8'hFB, 8'h7F; DONE after index 7.
- OREADY held low 10 cycles during index 2 -> OVALID, OADDR=2 and ODATA stable. No CLRN until accept; accept in cycle 11 -> CLRN[2]=0 next cycle.
- Mid-pass DIRTY[1] set after index 2 is sent, and DIRTY[5] set -> index 5 is emitted, index 1 is not.
- RST asserted while in SEND for index 2 -> next edge: all outputs at reset values, CLRN all ones. A new START re-drains index 2.
- DFFS_DRAIN_CLEAR_EN undefined, run case 2 -> same output stream; CLRN stays 8'hFF throughout.
